atm_keypad_frontend: RTL and testbench

- Customer-side input front-end for the ATM controller core.
- Collects the card insertion and ID from the card reader, then takes keypad entries for language, 4-digit PIN, operation and decimal amount.
- Presents one complete transaction to the core (InserCard, Language, Card_ID, PIN0-3, operation, CashDeposited/CashWithdrawed) with a valid/ready handshake.
- It is the driving end of the core's input interface.

---
 rtl/atm_keypad_frontend_if.sv | 30 +++
 rtl/atm_keypad_frontend.sv | 214 +++++++++++++++++++++
 tb/tb_atm_keypad_frontend.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/atm_keypad_frontend_if.sv
// Request bus from the keypad front-end to the ATM core.
// The front-end drives the transaction fields and req_valid, and the core answers with req_ready.
interface atm_keypad_frontend_if #(
  parameter int AMT_W = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             InserCard;
  logic             Language;
  logic [3:0]       Card_ID;
  logic [3:0]       PIN0;
  logic [3:0]       PIN1;
  logic [3:0]       PIN2;
  logic [3:0]       PIN3;
  logic [1:0]       operation;
  logic [AMT_W-1:0] CashDeposited;
  logic [AMT_W-1:0] CashWithdrawed;

  modport master (
    output req_valid, InserCard, Language, Card_ID, PIN0, PIN1, PIN2, PIN3,
           operation, CashDeposited, CashWithdrawed,
    input  req_ready
  );

  modport slave (
    input  req_valid, InserCard, Language, Card_ID, PIN0, PIN1, PIN2, PIN3,
           operation, CashDeposited, CashWithdrawed,
    output req_ready
  );
endinterface

// File: rtl/atm_keypad_frontend.sv
// ATM keypad front-end. It collects the card ID, language, PIN, operation and amount,
// then presents one transaction to the core over a valid/ready handshake.
// Optional macro KEYPAD_TIMEOUT_EN: an inactivity timeout in LANG..AMOUNT that acts like CANCEL.
module atm_keypad_frontend #(
  parameter int AMT_W          = 32,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  card_present,
  input  logic [3:0]            card_id_in,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic                  key_ready,
  atm_keypad_frontend_if.master core,
  output logic                  abort,
  output logic [2:0]            fsm_state
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, LANG = 3'd1, PIN = 3'd2, OP = 3'd3, AMOUNT = 3'd4, SEND = 3'd5, DONE = 3'd6
  } state_t;

  localparam logic [3:0] K_ENTER  = 4'hA;
  localparam logic [3:0] K_CLEAR  = 4'hB;
  localparam logic [3:0] K_CANCEL = 4'hC;

  state_t           state, state_n;
  logic             locked, locked_n;
  logic             inser, inser_n;
  logic             lang, lang_n;
  logic [3:0]       card_id, card_id_n;
  logic [3:0]       pin [4];
  logic [3:0]       pin_n [4];
  logic [2:0]       cnt, cnt_n;
  logic [1:0]       op, op_n;
  logic [AMT_W-1:0] acc, acc_n;
  logic             sat, sat_n;
  logic [AMT_W-1:0] dep, wd;
  logic             req_valid;
  logic             take, is_digit, clr, tmo;
  logic [AMT_W+3:0] acc_x10;

  assign take     = key_valid & key_ready;
  assign is_digit = (key_code <= 4'd9);
  assign acc_x10  = (AMT_W+4)'(acc) * (AMT_W+4)'(10) + (AMT_W+4)'(key_code);

`ifdef KEYPAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  logic          active;
  assign active = (state == LANG) || (state == PIN) || (state == OP) || (state == AMOUNT);
  assign tmo    = active && !take && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Inactivity counter: reloads on a consumed key or a state change, and is frozen outside LANG..AMOUNT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          idle_cnt <= '0;
    else if (take || state_n != state) idle_cnt <= '0;
    else if (active)                  idle_cnt <= idle_cnt + TW'(1);
  end
`else
  logic unused_timeout;
  assign tmo            = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Next-state and next-field computation. Card removal outranks any key in the same cycle.
  always_comb begin
    state_n   = state;
    locked_n  = locked;
    inser_n   = inser;
    lang_n    = lang;
    card_id_n = card_id;
    pin_n     = pin;
    cnt_n     = cnt;
    op_n      = op;
    acc_n     = acc;
    sat_n     = sat;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        // After a cancel, the locked flag keeps the same card from re-entering until it is removed.
        if (locked) begin
          if (!card_present) locked_n = 1'b0;
        end else if (card_present) begin
          card_id_n = card_id_in;
          inser_n   = 1'b1;
          state_n   = LANG;
        end
      end
      DONE: begin
        if (!card_present) begin
          clr     = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        if (!card_present) begin
          clr     = 1'b1;
          state_n = IDLE;
        end else if ((take && key_code == K_CANCEL) || tmo) begin
          clr      = 1'b1;
          locked_n = 1'b1;
          state_n  = IDLE;
        end else begin
          case (state)
            LANG: if (take && key_code <= 4'd1) begin
              lang_n  = key_code[0];
              state_n = PIN;
            end
            PIN: if (take) begin
              if (is_digit) begin
                if (cnt < 3'd4) begin
                  pin_n[cnt[1:0]] = key_code;
                  cnt_n           = cnt + 3'd1;
                end
              end else if (key_code == K_ENTER) begin
                if (cnt == 3'd4) state_n = OP;
              end else if (key_code == K_CLEAR) begin
                pin_n = '{default: '0};
                cnt_n = '0;
              end
            end
            OP: if (take && key_code <= 4'd3) begin
              op_n    = key_code[1:0];
              acc_n   = '0;
              sat_n   = 1'b0;
              state_n = (key_code[1:0] == 2'd1 || key_code[1:0] == 2'd2) ? AMOUNT : SEND;
            end
            AMOUNT: if (take) begin
              if (is_digit) begin
                if (!sat) begin
                  if (|acc_x10[AMT_W+3:AMT_W]) begin
                    acc_n = '1;
                    sat_n = 1'b1;
                  end else begin
                    acc_n = acc_x10[AMT_W-1:0];
                  end
                end
              end else if (key_code == K_ENTER) begin
                state_n = SEND;
              end else if (key_code == K_CLEAR) begin
                acc_n = '0;
                sat_n = 1'b0;
              end
            end
            SEND: if (req_valid && core.req_ready) state_n = DONE;
            default: ;
          endcase
        end
      end
    endcase
    if (clr) begin
      inser_n   = 1'b0;
      lang_n    = 1'b0;
      card_id_n = '0;
      pin_n     = '{default: '0};
      cnt_n     = '0;
      op_n      = '0;
      acc_n     = '0;
      sat_n     = 1'b0;
    end
  end

  // State and output registers. Cash outputs route the accumulator by operation every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      locked    <= 1'b0;
      inser     <= 1'b0;
      lang      <= 1'b0;
      card_id   <= '0;
      pin       <= '{default: '0};
      cnt       <= '0;
      op        <= '0;
      acc       <= '0;
      sat       <= 1'b0;
      dep       <= '0;
      wd        <= '0;
      req_valid <= 1'b0;
      key_ready <= 1'b0;
      abort     <= 1'b0;
    end else begin
      state     <= state_n;
      locked    <= locked_n;
      inser     <= inser_n;
      lang      <= lang_n;
      card_id   <= card_id_n;
      pin       <= pin_n;
      cnt       <= cnt_n;
      op        <= op_n;
      acc       <= acc_n;
      sat       <= sat_n;
      dep       <= (op_n == 2'd1) ? acc_n : '0;
      wd        <= (op_n == 2'd2) ? acc_n : '0;
      req_valid <= (state_n == SEND);
      key_ready <= (state_n == LANG) || (state_n == PIN) || (state_n == OP) || (state_n == AMOUNT);
      // Completing a transaction (DONE -> IDLE) is not an abandoned session, so it raises no abort.
      abort     <= clr && (state != DONE);
    end
  end

  assign fsm_state           = state;
  assign core.req_valid      = req_valid;
  assign core.InserCard      = inser;
  assign core.Language       = lang;
  assign core.Card_ID        = card_id;
  assign core.PIN0           = pin[0];
  assign core.PIN1           = pin[1];
  assign core.PIN2           = pin[2];
  assign core.PIN3           = pin[3];
  assign core.operation      = op;
  assign core.CashDeposited  = dep;
  assign core.CashWithdrawed = wd;
endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Testbench for atm_keypad_frontend. Stimulus pushes the expected transactions and aborts into a queue,
// and a monitor pops and compares them whenever the DUT completes a handshake or pulses abort.
module tb_atm_keypad_frontend;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       card_present = 1'b0;
  logic [3:0] card_id_in = '0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = '0;
  logic       key_ready;
  logic       abort;
  logic [2:0] fsm_state;

  atm_keypad_frontend_if #(.AMT_W(32)) bus ();

  atm_keypad_frontend #(.AMT_W(32), .TIMEOUT_CYCLES(20)) dut (
    .clk          (clk),
    .rst          (rst),
    .card_present (card_present),
    .card_id_in   (card_id_in),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ready    (key_ready),
    .core         (bus),
    .abort        (abort),
    .fsm_state    (fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_abort;
    logic [3:0]  id;
    logic        lang;
    logic [15:0] pins;
    logic [1:0]  op;
    logic [31:0] dep;
    logic [31:0] wd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    step(1);
    key_valid = 1'b0;
  endtask

  task automatic insert(input logic [3:0] id);
    card_id_in   = id;
    card_present = 1'b1;
    step(1);
  endtask

  task automatic remove_card();
    card_present = 1'b0;
    step(1);
  endtask

  task automatic push_txn(input logic [3:0] id, input logic lang, input logic [15:0] pins,
                          input logic [1:0] op, input logic [31:0] dep, input logic [31:0] wd);
    exp_t e;
    e.is_abort = 1'b0; e.id = id; e.lang = lang; e.pins = pins; e.op = op; e.dep = dep; e.wd = wd;
    q.push_back(e);
  endtask

  task automatic push_abort();
    exp_t e;
    e = '{is_abort: 1'b1, id: '0, lang: 1'b0, pins: '0, op: '0, dep: '0, wd: '0};
    q.push_back(e);
  endtask

  task automatic handshake();
    bus.req_ready = 1'b1;
    step(1);
    bus.req_ready = 1'b0;
  endtask

  // Monitor: compares every abort pulse and every accepted transaction against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (abort === 1'b1) begin
        chk("abort_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("abort_kind", 64'(e.is_abort), 64'd1);
        end
      end
      if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1) begin
        chk("txn_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("txn_kind", 64'(e.is_abort), 64'd0);
          chk("txn_card_id", 64'(bus.Card_ID), 64'(e.id));
          chk("txn_language", 64'(bus.Language), 64'(e.lang));
          chk("txn_pin", 64'({bus.PIN0, bus.PIN1, bus.PIN2, bus.PIN3}), 64'(e.pins));
          chk("txn_operation", 64'(bus.operation), 64'(e.op));
          chk("txn_deposit", 64'(bus.CashDeposited), 64'(e.dep));
          chk("txn_withdraw", 64'(bus.CashWithdrawed), 64'(e.wd));
          chk("txn_inser", 64'(bus.InserCard), 64'd1);
        end
      end
    end
  end

  initial begin
    bus.req_ready = 1'b0;
    step(2);
    // Reset state
    chk("rst_req_valid", 64'(bus.req_valid), 64'd0);
    chk("rst_inser", 64'(bus.InserCard), 64'd0);
    chk("rst_key_ready", 64'(key_ready), 64'd0);
    chk("rst_state", 64'(fsm_state), 64'd0);
    chk("rst_abort", 64'(abort), 64'd0);
    chk("rst_fields", 64'({bus.Card_ID, bus.PIN0, bus.PIN1, bus.PIN2, bus.PIN3, bus.operation, bus.Language}), 64'd0);
    rst = 1'b0;
    step(1);

    // Balance
    insert(4'd1);
    chk("bal_state_lang", 64'(fsm_state), 64'd1);
    chk("bal_card_id", 64'(bus.Card_ID), 64'd1);
    chk("bal_inser", 64'(bus.InserCard), 64'd1);
    key(4'd1);
    for (int unsigned i = 0; i < 4; i++) key(4'd1);
    key(4'hA);
    push_txn(4'd1, 1'b1, 16'h1111, 2'd0, 32'd0, 32'd0);
    key(4'd0);
    chk("bal_req_valid_latency", 64'(bus.req_valid), 64'd1);
    handshake();
    chk("bal_state_done", 64'(fsm_state), 64'd6);
    chk("bal_req_valid_drop", 64'(bus.req_valid), 64'd0);
    chk("bal_inser_done", 64'(bus.InserCard), 64'd1);
    remove_card();
    chk("bal_idle", 64'(fsm_state), 64'd0);
    chk("bal_cleared", 64'({bus.InserCard, bus.Card_ID, bus.PIN0, bus.Language}), 64'd0);

    // Deposit with a held-off handshake
    insert(4'd2);
    key(4'd1);
    for (int unsigned i = 0; i < 4; i++) key(4'd2);
    key(4'hA);
    key(4'd1);
    key(4'd1); key(4'd0); key(4'd0);
    chk("dep_amount_track", 64'(bus.CashDeposited), 64'd100);
    push_txn(4'd2, 1'b1, 16'h2222, 2'd1, 32'd100, 32'd0);
    key(4'hA);
    for (int unsigned i = 0; i < 5; i++) begin
      step(1);
      chk("dep_hold_valid", 64'(bus.req_valid), 64'd1);
      chk("dep_hold_amount", 64'(bus.CashDeposited), 64'd100);
      chk("dep_hold_pin3", 64'(bus.PIN3), 64'd2);
    end
    handshake();
    remove_card();

    // Withdraw with saturation, then CLEAR
    insert(4'd3);
    key(4'd0);
    key(4'd5); key(4'd6); key(4'd7); key(4'd8);
    key(4'hA);
    key(4'd2);
    key(4'd4); key(4'd2); key(4'd9); key(4'd4); key(4'd9);
    key(4'd6); key(4'd7); key(4'd2); key(4'd9); key(4'd5);
    chk("sat_max_exact", 64'(bus.CashWithdrawed), 64'hFFFF_FFFF);
    key(4'd9);
    chk("sat_overflow", 64'(bus.CashWithdrawed), 64'hFFFF_FFFF);
    key(4'd1);
    chk("sat_sticky", 64'(bus.CashWithdrawed), 64'hFFFF_FFFF);
    key(4'hB);
    chk("sat_clear", 64'(bus.CashWithdrawed), 64'd0);
    key(4'd2); key(4'd0); key(4'd0);
    chk("wd_200", 64'(bus.CashWithdrawed), 64'd200);
    chk("wd_dep_zero", 64'(bus.CashDeposited), 64'd0);
    push_txn(4'd3, 1'b0, 16'h5678, 2'd2, 32'd0, 32'd200);
    key(4'hA);
    handshake();
    remove_card();

    // PIN edge cases, then CANCEL in OP
    insert(4'd4);
    key(4'd1);
    key(4'd9); key(4'd8); key(4'd7);
    key(4'hA);
    chk("pin_short_enter", 64'(fsm_state), 64'd2);
    key(4'd6);
    key(4'd5);
    chk("pin_fifth_ignored", 64'({bus.PIN0, bus.PIN1, bus.PIN2, bus.PIN3}), 64'h9876);
    key(4'hB);
    chk("pin_clear", 64'({bus.PIN0, bus.PIN1, bus.PIN2, bus.PIN3}), 64'h0000);
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    key(4'hA);
    chk("pin_to_op", 64'(fsm_state), 64'd3);
    chk("pin_restart", 64'({bus.PIN0, bus.PIN1, bus.PIN2, bus.PIN3}), 64'h1234);
    push_abort();
    key(4'hC);
    chk("cancel_inser", 64'(bus.InserCard), 64'd0);
    chk("cancel_req_valid", 64'(bus.req_valid), 64'd0);
    chk("cancel_pin_clear", 64'(bus.PIN0), 64'd0);
    step(3);
    chk("cancel_locked", 64'(bus.InserCard), 64'd0);
    chk("cancel_no_reentry", 64'(key_ready), 64'd0);
    remove_card();

    // Card removal in AMOUNT with a key in the same cycle
    insert(4'd5);
    key(4'd0);
    for (int unsigned i = 0; i < 4; i++) key(4'd1);
    key(4'hA);
    key(4'd1);
    key(4'd7);
    chk("amt_state", 64'(fsm_state), 64'd4);
    push_abort();
    card_present = 1'b0;
    key(4'd8);
    chk("remove_idle", 64'(fsm_state), 64'd0);
    chk("remove_dep_zero", 64'(bus.CashDeposited), 64'd0);
    chk("remove_inser", 64'(bus.InserCard), 64'd0);
    step(1);
    chk("abort_one_cycle", 64'(abort), 64'd0);

    // Asynchronous reset while in SEND
    insert(4'd6);
    key(4'd1);
    for (int unsigned i = 0; i < 4; i++) key(4'd2);
    key(4'hA);
    key(4'd0);
    chk("send_valid", 64'(bus.req_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(bus.req_valid), 64'd0);
    chk("async_rst_state", 64'(fsm_state), 64'd0);
    chk("async_rst_inser", 64'(bus.InserCard), 64'd0);
    card_present = 1'b0;
    step(1);
    rst = 1'b0;
    step(1);

`ifdef KEYPAD_TIMEOUT_EN
    insert(4'd7);
    key(4'd1);
    push_abort();
    step(25);
    chk("tmo_idle", 64'(fsm_state), 64'd0);
    remove_card();
    insert(4'd8);
    key(4'd0);
    for (int unsigned i = 0; i < 3; i++) begin
      step(14);
      key(4'd1);
    end
    chk("tmo_keys_keep_alive", 64'(fsm_state), 64'd2);
    chk("tmo_inser", 64'(bus.InserCard), 64'd1);
    push_abort();
    key(4'hC);
    remove_card();
`endif

    step(3);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
